ahb_line_master: RTL and testbench
==================================

Name: ahb_line_master

Overview:
- AHB-lite initiator for the cache side of the bus; it is the requesting end paired with the `ahb_lite` memory responder.
- Accepts one cache-miss request at a time.
- When the victim line is dirty, it first writes that 4-word (128-bit) line back, then fills the new line with a 128-bit read.
- Returns the fill data to the cache with a one-cycle response pulse. A bus watchdog aborts a transfer that never completes.

Parameters:
- ADDR_W, 32, address width of HADDR and the request addresses.
- LINE_W, 128, line data width (4 x 32-bit words).
- TIMEOUT, 64, cycles to wait for HREADY in one phase before aborting; 0 disables the watchdog.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  cache miss request.
- req_ready  out  1  master can accept a request.
- req_dirty  in  1  victim line must be written back before the fill.
- req_fill_addr  in  ADDR_W  address of the line to read.
- req_wb_addr  in  ADDR_W  address of the victim line.
- req_wb_data  in  LINE_W  victim line data.
- rsp_valid  out  1  one-cycle pulse; the response is complete.
- rsp_data  out  LINE_W  fill data; valid while rsp_valid is high.
- rsp_error  out  1  watchdog abort; qualified by rsp_valid.
- HADDR  out  ADDR_W  bus address.
- HWRITE  out  1  1 = write.
- HTRANS  out  2  2'b00 IDLE, 2'b10 NONSEQ.
- HWDATA  out  LINE_W  write data.
- HRDATA  in  LINE_W  read data.
- HREADY  in  1  transfer complete, sampled at posedge HCLK.

Behaviour:
- One clock, HCLK. Reset HRESET is asynchronous and active-high.
- While HRESET is high:
  - State is IDLE; req_ready=0, rsp_valid=0, rsp_error=0, rsp_data=0.
  - HADDR=0, HWRITE=0, HTRANS=IDLE, HWDATA=0.
  - Watchdog count is 0.
- FSM states: IDLE, WB, FILL, RESP.
- IDLE:
  - req_ready=1 (only in IDLE, and only while HRESET is low).
  - On req_valid&req_ready at a posedge: latch all req_* inputs. Go to WB if req_dirty, else to FILL.
- Addresses: latched addresses have bits [3:0] forced to 0 (line-aligned).
- WB:
  - Drive HTRANS=NONSEQ, HWRITE=1, HADDR=wb_addr, HWDATA=wb_data.
  - Data is presented in the same cycle as the address (this bus samples both together, unlike pipelined AHB).
  - Hold all four outputs stable until HREADY=1 at a posedge, then go to FILL.
- FILL:
  - Drive HTRANS=NONSEQ, HWRITE=0, HADDR=fill_addr, HWDATA=0.
  - On HREADY=1 at a posedge: register HRDATA into rsp_data and go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; bus outputs are at their idle values.
  - Next state is IDLE.
  - A new request is accepted no earlier than the cycle after rsp_valid.
- Latency with zero wait states, counted from the accept edge:
  - Dirty request: WB in cycle 1, FILL in cycle 2, rsp_valid in cycle 3.
  - Clean request: FILL in cycle 1, rsp_valid in cycle 2.
  - Each wait state adds one cycle.
- Watchdog:
  - Counter clears on entry to WB or FILL and increments each cycle in that phase with HREADY=0.
  - When the count reaches TIMEOUT with HREADY still 0: abort, go to RESP with rsp_error=1 and rsp_data=0. A WB timeout skips FILL.
  - HREADY=1 in the same cycle as the count reaching TIMEOUT counts as completion, not an error.
- HREADY high in IDLE or RESP is ignored. req_valid outside IDLE is ignored; the requester must hold its request.
- Reset asserted mid-transfer: immediate abandon, outputs go to their reset values asynchronously, and no rsp_valid is produced.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS_IDLE/HTRANS_NONSEQ constants.
  - The master state enum typedef.
  - LINE_OFFSET_BITS=4.
- Sub-module ahb_watchdog: counter with clear, enable and TIMEOUT parameter, outputting `expired`. Reused by the future I-side master.

Test Plan:
- Clean miss, fill_addr=0x0000_1234, HREADY tied high:
  - Cycle 1: HADDR=0x0000_1230, HWRITE=0, HTRANS=2'b10.
  - Cycle 2: rsp_valid=1 with rsp_data equal to the HRDATA driven in cycle 1 (e.g. 128'hDEAD…0001).
- Dirty miss, wb_addr=0x100, wb_data=128'h1111_2222_3333_4444_…, fill_addr=0x200, HREADY high:
  - Cycle 1: HWRITE=1, HADDR=0x100, HWDATA=wb_data.
  - Cycle 2: HADDR=0x200, HWRITE=0.
  - Cycle 3: rsp_valid=1.
- Wait states: HREADY low for 3 cycles in FILL → HADDR/HWRITE stable for 4 cycles, rsp_valid asserts 4 cycles after FILL entry, rsp_error=0.
- Timeout with TIMEOUT=4 and HREADY stuck at 0 on a dirty request:
  - Exactly 4 WB cycles, no FILL cycle.
  - rsp_valid=1 with rsp_error=1 and rsp_data=0, then req_ready=1 the next cycle.
- Reset in the middle of FILL: HTRANS=0, HADDR=0, req_ready=0 immediately with no clock edge; no rsp_valid follows. After release, req_ready=1 and a new request completes normally.
- Back-to-back: req_valid held high continuously → accepts occur only in IDLE cycles, never while rsp_valid=1, and exactly one rsp_valid per accept.

Source files
------------

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-lite master constants and state type
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // A line is 16 bytes; request addresses are aligned to this boundary.
    localparam int LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WB,
        ST_FILL,
        ST_RESP
    } master_state_t;

endpackage

// File: rtl/ahb_watchdog.sv
// rtl/ahb_watchdog.sv - bus phase watchdog counter
// Ports: clk, rst (async, active-high), clear (zero the count), enable
// (count this cycle), expired (this cycle's count reaches TIMEOUT).
module ahb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // expired is combinational: it flags the cycle whose increment would
    // bring the count to TIMEOUT, so the caller can abort on that edge.
    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            assign expired = enable && (count == CW'(TIMEOUT - 1));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired && (TIMEOUT != 0)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ahb_line_master.sv
// rtl/ahb_line_master.sv - AHB-lite cache line write-back/fill master
// Ports: HCLK, HRESET (async, active-high); request side req_valid/req_ready,
// req_dirty, req_fill_addr, req_wb_addr, req_wb_data; response side
// rsp_valid (1-cycle pulse), rsp_data, rsp_error; bus side HADDR, HWRITE,
// HTRANS, HWDATA, HRDATA, HREADY.
module ahb_line_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_dirty,
    input  logic [ADDR_W-1:0] req_fill_addr,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [LINE_W-1:0] req_wb_data,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_data,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [LINE_W-1:0] HWDATA,
    input  logic [LINE_W-1:0] HRDATA,
    input  logic              HREADY
);

    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

    master_state_t state, next_state;

    logic [ADDR_W-1:0] fill_addr_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [LINE_W-1:0] wb_data_q;

    logic in_phase;
    logic wd_clear;
    logic wd_en;
    logic wd_expired;

    assign in_phase = (state == ST_WB) || (state == ST_FILL);
    assign wd_en    = in_phase && !HREADY;
    // Clearing throughout IDLE covers entry into either phase from IDLE;
    // the WB->FILL hand-over is the only other phase entry.
    assign wd_clear = (state == ST_IDLE) || ((state == ST_WB) && HREADY);

    ahb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (HCLK),
        .rst     (HRESET),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Bus outputs are decoded from the registered state so that an
    // asynchronous reset returns them to idle values without a clock edge.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        HADDR      = '0;
        HWRITE     = 1'b0;
        HTRANS     = HTRANS_IDLE;
        HWDATA     = '0;
        case (state)
            ST_IDLE: begin
                req_ready = !HRESET;
                if (req_valid && !HRESET) begin
                    next_state = req_dirty ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                HTRANS = HTRANS_NONSEQ;
                HWRITE = 1'b1;
                HADDR  = wb_addr_q;
                HWDATA = wb_data_q;
                if (HREADY) begin
                    next_state = ST_FILL;
                end else if (wd_expired) begin
                    next_state = ST_RESP;
                end
            end
            ST_FILL: begin
                HTRANS = HTRANS_NONSEQ;
                HADDR  = fill_addr_q;
                if (HREADY || wd_expired) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid  = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            fill_addr_q <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            rsp_data    <= '0;
            rsp_error   <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && req_valid) begin
                fill_addr_q <= req_fill_addr & LINE_MASK;
                wb_addr_q   <= req_wb_addr & LINE_MASK;
                wb_data_q   <= req_wb_data;
                rsp_error   <= 1'b0;
            end
            // HREADY wins over expiry in the same cycle (wd_expired already
            // requires HREADY low), so a late completion is not an error.
            if ((state == ST_FILL) && HREADY) begin
                rsp_data  <= HRDATA;
                rsp_error <= 1'b0;
            end else if (in_phase && wd_expired) begin
                rsp_data  <= '0;
                rsp_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_line_master.sv
// tb/tb_ahb_line_master.sv - randomized self-checking bench for ahb_line_master
module tb_ahb_line_master;

    localparam int TO = 4;

    logic         HCLK;
    logic         HRESET;
    logic         req_valid;
    logic         req_ready;
    logic         req_dirty;
    logic [31:0]  req_fill_addr;
    logic [31:0]  req_wb_addr;
    logic [127:0] req_wb_data;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         rsp_error;
    logic [31:0]  HADDR;
    logic         HWRITE;
    logic [1:0]   HTRANS;
    logic [127:0] HWDATA;
    logic [127:0] HRDATA;
    logic         HREADY;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_line_master #(
        .ADDR_W  (32),
        .LINE_W  (128),
        .TIMEOUT (TO)
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dirty     (req_dirty),
        .req_fill_addr (req_fill_addr),
        .req_wb_addr   (req_wb_addr),
        .req_wb_data   (req_wb_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_error     (rsp_error),
        .HADDR         (HADDR),
        .HWRITE        (HWRITE),
        .HTRANS        (HTRANS),
        .HWDATA        (HWDATA),
        .HRDATA        (HRDATA),
        .HREADY        (HREADY)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Random request-side noise while the master is busy; it must be ignored.
    task automatic noise_req();
        req_valid     = 1'($urandom % 2);
        req_dirty     = 1'($urandom % 2);
        req_fill_addr = $urandom;
        req_wb_addr   = $urandom;
        req_wb_data   = rnd128();
    endtask

    task automatic wait_ready(input string tag);
        int g;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge HCLK);
            g++;
        end
        check(tag, req_ready, 1'b1);
    endtask

    // One miss. wwb / wfill are the number of HREADY-low cycles the slave
    // inserts before completing each phase; >= TO means it never completes.
    task automatic run_req(input bit dirty, input logic [31:0] fa, input logic [31:0] wa,
                           input logic [127:0] wd, input int wwb, input int wfill);
        bit           exp_err;
        logic [127:0] exp_data;
        logic [127:0] rd;
        int           nwb, nf;
        wait_ready("ready_before_req");
        req_valid     = 1'b1;
        req_dirty     = dirty;
        req_fill_addr = fa;
        req_wb_addr   = wa;
        req_wb_data   = wd;
        HREADY        = 1'($urandom % 2);
        HRDATA        = rnd128();
        @(negedge HCLK);
        exp_err  = 1'b0;
        exp_data = '0;
        if (dirty) begin
            nwb = (wwb >= TO) ? TO : wwb + 1;
            for (int k = 1; k <= nwb; k++) begin
                check("wb_htrans", HTRANS, 2'b10);
                check("wb_hwrite", HWRITE, 1'b1);
                check("wb_haddr", HADDR, {wa[31:4], 4'h0});
                check("wb_hwdata", HWDATA, wd);
                check("wb_rsp_valid", rsp_valid, 1'b0);
                check("wb_req_ready", req_ready, 1'b0);
                noise_req();
                HREADY = (k > wwb);
                HRDATA = rnd128();
                @(negedge HCLK);
            end
            if (wwb >= TO) exp_err = 1'b1;
        end
        if (!exp_err) begin
            nf = (wfill >= TO) ? TO : wfill + 1;
            for (int k = 1; k <= nf; k++) begin
                check("fill_htrans", HTRANS, 2'b10);
                check("fill_hwrite", HWRITE, 1'b0);
                check("fill_haddr", HADDR, {fa[31:4], 4'h0});
                check("fill_hwdata", HWDATA, 128'h0);
                check("fill_rsp_valid", rsp_valid, 1'b0);
                noise_req();
                HREADY = (k > wfill);
                rd     = rnd128();
                HRDATA = rd;
                if (k > wfill) exp_data = rd;
                @(negedge HCLK);
            end
            if (wfill >= TO) exp_err = 1'b1;
        end
        req_valid = 1'b0;
        HREADY    = 1'($urandom % 2);
        check("resp_valid", rsp_valid, 1'b1);
        check("resp_error", rsp_error, exp_err);
        check("resp_data", rsp_data, exp_data);
        check("resp_htrans", HTRANS, 2'b00);
        check("resp_req_ready", req_ready, 1'b0);
        @(negedge HCLK);
        check("after_rsp_valid", rsp_valid, 1'b0);
        check("after_req_ready", req_ready, 1'b1);
    endtask

    initial begin
        int acc, rsp, per, exp_acc;
        bit d;
        HRESET        = 1'b1;
        req_valid     = 1'b1;
        req_dirty     = 1'b1;
        req_fill_addr = 32'h55;
        req_wb_addr   = 32'h66;
        req_wb_data   = rnd128();
        HREADY        = 1'b1;
        HRDATA        = rnd128();
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_error", rsp_error, 1'b0);
        check("rst_rsp_data", rsp_data, 128'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwrite", HWRITE, 1'b0);
        check("rst_htrans", HTRANS, 2'b00);
        check("rst_hwdata", HWDATA, 128'h0);
        repeat (3) @(negedge HCLK);
        check("rst_hold_htrans", HTRANS, 2'b00);
        req_valid = 1'b0;
        HRESET    = 1'b0;
        @(negedge HCLK);
        check("post_rst_ready", req_ready, 1'b1);

        // Directed misses: clean, dirty, fill wait states, WB timeout,
        // FILL timeout, and completion on the last allowed cycle.
        run_req(1'b0, 32'h0000_1234, 32'h0, 128'h0, 0, 0);
        run_req(1'b1, 32'h200, 32'h100, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 0);
        run_req(1'b0, 32'h0000_4568, 32'h0, 128'h0, 0, 3);
        run_req(1'b1, 32'h300, 32'h400, rnd128(), 9, 0);
        run_req(1'b0, 32'h500, 32'h0, 128'h0, 0, TO);
        run_req(1'b1, 32'h600, 32'h70F, rnd128(), TO - 1, TO - 1);

        // Reset in the middle of FILL.
        wait_ready("rst_mid_ready");
        req_valid     = 1'b1;
        req_dirty     = 1'b0;
        req_fill_addr = 32'h0000_ABC0;
        @(negedge HCLK);
        req_valid = 1'b0;
        HREADY    = 1'b0;
        check("mid_fill_htrans", HTRANS, 2'b10);
        #2 HRESET = 1'b1;
        #1;
        check("mid_rst_htrans", HTRANS, 2'b00);
        check("mid_rst_haddr", HADDR, 32'h0);
        check("mid_rst_req_ready", req_ready, 1'b0);
        HREADY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            check("mid_rst_no_rsp", rsp_valid, 1'b0);
        end
        HRESET = 1'b0;
        #1;
        check("mid_rst_release_ready", req_ready, 1'b1);
        @(negedge HCLK);
        check("mid_rst_no_rsp_after", rsp_valid, 1'b0);
        run_req(1'b0, 32'h0000_0F10, 32'h0, 128'h0, 1, 1);

        // Randomized misses.
        for (int t = 0; t < 40; t++) begin
            run_req(1'($urandom % 2), $urandom, $urandom, rnd128(),
                    int'($urandom_range(0, TO + 1)), int'($urandom_range(0, TO + 1)));
        end

        // Back-to-back with req_valid held high and zero wait states.
        d = 1'($urandom % 2);
        per = d ? 4 : 3;
        exp_acc = (30 + per - 1) / per;
        acc = 0;
        rsp = 0;
        req_valid     = 1'b1;
        req_dirty     = d;
        req_fill_addr = $urandom;
        req_wb_addr   = $urandom;
        req_wb_data   = rnd128();
        HREADY        = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (req_ready) acc++;
            if (rsp_valid) rsp++;
            check("b2b_no_overlap", req_ready & rsp_valid, 1'b0);
            @(negedge HCLK);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid) rsp++;
            @(negedge HCLK);
        end
        check("b2b_accepts", acc, exp_acc);
        check("b2b_one_rsp_per_accept", rsp, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
